// File: rtl/far_mem_responder_pkg.sv
// Far-memory responder: shared request/response types and constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Holds the cache<->FM request/response structs, the FM opcode enum, the
// response-queue entry layout and a helper for the initial entry countdown.
package far_mem_responder_pkg;

  localparam int CL_WIDTH    = 64;  // cache-line payload width
  localparam int LINE_ADDR_W = 26;  // line-address width
  localparam int TQ_ID_W     = 4;   // transaction-queue id width
  localparam int FM_CNT_W    = 8;   // countdown width; supports latency up to 255
  localparam int FM_LATENCY  = 8;   // default request-to-response latency

  typedef enum logic [1:0] {
    FM_NOP_OP      = 2'd0,
    FILL_REQ_OP    = 2'd1,
    DIRTY_EVICT_OP = 2'd2
  } t_fm_opcode;

  typedef logic [LINE_ADDR_W-1:0] t_line_addr;
  typedef logic [CL_WIDTH-1:0]    t_cl_data;
  typedef logic [TQ_ID_W-1:0]     t_tq_id;

  typedef struct packed {
    logic       valid;
    t_fm_opcode opcode;
    t_line_addr address;
    t_cl_data   data;
    t_tq_id     tq_id;
  } t_fm_req;

  typedef struct packed {
    logic       valid;
    t_line_addr address;
    t_cl_data   data;
    t_tq_id     tq_id;
  } t_fm_rd_rsp;

  typedef struct packed {
    t_line_addr          address;
    t_tq_id              tq_id;
    t_cl_data            data;
    logic [FM_CNT_W-1:0] cnt;
  } t_fm_rsp_entry;

  // An entry spends one cycle in the queue per count plus the pop edge, so
  // it starts at LATENCY-1 to make the registered output land LATENCY edges
  // after the accept edge.
  function automatic logic [FM_CNT_W-1:0] fm_init_cnt(input int latency);
    return FM_CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/far_mem_responder_rsp_fifo.sv
// Purpose: in-order response queue whose entries each count down to ready.
// Latency: push visible at head next cycle; head_ready once head cnt hits 0.
// Backpressure: none internally; caller must not push when full without a pop.
//
// Ports:
//   clk, rst        clock, async active-high reset (empties the queue)
//   push_i          write push_entry_i at the tail
//   push_entry_i    entry to store, cnt field is its starting countdown
//   pop_i           drop the head entry
//   head_o          current head entry
//   head_ready_o    head present and its countdown has expired
//   full_o/empty_o  occupancy flags
//   count_o         number of stored entries
module fm_rsp_fifo
  import far_mem_responder_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = t_fm_rsp_entry,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  T                 push_entry_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic             head_ready_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 slots_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every slot counts down, occupied or not: free slots are overwritten on
  // push, so their count is irrelevant and no per-slot valid bit is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && (wr_ptr_q == PTR_W'(i))) begin
        slots_q[i] <= push_entry_i;
      end else if (slots_q[i].cnt != '0) begin
        slots_q[i].cnt <= slots_q[i].cnt - FM_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o       = slots_q[rd_ptr_q];
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign head_ready_o = !empty_o && (head_o.cnt == '0);
  assign count_o      = count_q;

endmodule

// File: rtl/far_mem_responder.sv
// Purpose: far-memory end of the cache<->FM link; line store plus timed fills.
// Latency: fill accepted at edge N gives rsp valid in the cycle after edge N+LATENCY.
// Backpressure: none; fills arriving with the queue full and no pop are dropped.
//
// Ports:
//   clk              clock
//   rst              async reset, active-high
//   cache2fm_req_q3  request: valid, opcode, line address, line data, tq_id
//   fm2cache_rd_rsp  registered fill response: valid, address, data, tq_id
//   rsp_pending      fills accepted minus responses issued
//   fm_ovf_err       sticky: a fill was dropped because the queue was full
module far_mem_responder
  import far_mem_responder_pkg::*;
#(
  parameter int  LATENCY        = FM_LATENCY,
  parameter int  RSP_FIFO_DEPTH = 8,
  parameter int  MEM_LINES      = 256,
  localparam int PEND_W         = $clog2(RSP_FIFO_DEPTH + 1),
  localparam int IDX_W          = $clog2(MEM_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  t_fm_req           cache2fm_req_q3,
  output t_fm_rd_rsp        fm2cache_rd_rsp,
  output logic [PEND_W-1:0] rsp_pending,
  output logic              fm_ovf_err
);

  // Backing store is deliberately not reset so data survives a reset pulse.
  t_cl_data mem_q [MEM_LINES];

  logic [IDX_W-1:0] idx;
  logic             fill_vld;
  logic             evict_vld;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_ready;
  t_fm_rsp_entry    push_entry;
  t_fm_rsp_entry    head_entry;

  t_fm_rd_rsp rsp_q, rsp_d;
  logic       ovf_q, ovf_d;

  // Upper address bits alias onto the same line by design.
  assign idx       = cache2fm_req_q3.address[IDX_W-1:0];
  assign fill_vld  = cache2fm_req_q3.valid && (cache2fm_req_q3.opcode == FILL_REQ_OP);
  assign evict_vld = cache2fm_req_q3.valid && (cache2fm_req_q3.opcode == DIRTY_EVICT_OP);

  // A head leaving this cycle frees a slot, so a fill into a full queue
  // still succeeds when it coincides with a pop.
  assign pop  = head_ready;
  assign push = fill_vld && (!fifo_full || pop);

  always_comb begin
    push_entry         = '0;
    push_entry.address = cache2fm_req_q3.address;
    push_entry.tq_id   = cache2fm_req_q3.tq_id;
    push_entry.data    = mem_q[idx];
    push_entry.cnt     = fm_init_cnt(LATENCY);
  end

  always_ff @(posedge clk) begin
    if (evict_vld) begin
      mem_q[idx] <= cache2fm_req_q3.data;
    end
  end

  fm_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .T     (t_fm_rsp_entry)
  ) u_rsp_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head_entry),
    .head_ready_o (head_ready),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (rsp_pending)
  );

  // Payload fields hold their last value while idle; only valid is pulsed.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_d.valid = 1'b0;
    if (pop) begin
      rsp_d.valid   = 1'b1;
      rsp_d.address = head_entry.address;
      rsp_d.data    = head_entry.data;
      rsp_d.tq_id   = head_entry.tq_id;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (fill_vld && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      ovf_q <= ovf_d;
    end
  end

  assign fm2cache_rd_rsp = rsp_q;
  assign fm_ovf_err      = ovf_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (!fifo_full || pop));

  a_pop_needs_entry: assert property (@(posedge clk) disable iff (rst)
    pop |-> (!fifo_empty && (head_entry.cnt == '0)));

  a_rsp_has_fill: assert property (@(posedge clk) disable iff (rst)
    fm2cache_rd_rsp.valid |-> $past(pop));

  a_latency_range: assert property (@(posedge clk) disable iff (rst)
    (LATENCY >= 1) && (LATENCY <= 255));

endmodule

// File: tb/tb_far_mem_responder.sv
// Bench for far_mem_responder: directed requests into two instances
// (LATENCY 8 and 16, depth 8); expected responses are queued at issue and
// a negedge monitor pops and compares them, including the arrival cycle.
module tb_far_mem_responder;
  import far_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  t_fm_req    req8, req16;
  t_fm_rd_rsp rsp8, rsp16;
  logic [3:0] pend8, pend16;
  logic       ovf8, ovf16;

  far_mem_responder #(.LATENCY(8), .RSP_FIFO_DEPTH(8), .MEM_LINES(256)) u_dut8 (
    .clk             (clk),
    .rst             (rst),
    .cache2fm_req_q3 (req8),
    .fm2cache_rd_rsp (rsp8),
    .rsp_pending     (pend8),
    .fm_ovf_err      (ovf8)
  );

  far_mem_responder #(.LATENCY(16), .RSP_FIFO_DEPTH(8), .MEM_LINES(256)) u_dut16 (
    .clk             (clk),
    .rst             (rst),
    .cache2fm_req_q3 (req16),
    .fm2cache_rd_rsp (rsp16),
    .rsp_pending     (pend16),
    .fm_ovf_err      (ovf16)
  );

  typedef struct {
    int         due;
    t_line_addr addr;
    t_cl_data   data;
    t_tq_id     tq;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   peak8  = 0;

  localparam logic [63:0] DAT_A = 64'hA5A5_0000_1111_0005;
  localparam logic [63:0] DAT_B = 64'hBEEF_0000_2222_0009;
  localparam logic [63:0] DAT_C = 64'hC0DE_0000_3333_0032;
  localparam logic [63:0] DAT_D = 64'hDEAD_0000_4444_0009;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void cmp_rsp(input string tag, input t_fm_rd_rsp r, input exp_t e);
    check({tag, "_cycle"}, 128'(cyc), 128'(e.due));
    check({tag, "_addr"},  128'(r.address), 128'(e.addr));
    check({tag, "_data"},  128'(r.data), 128'(e.data));
    check({tag, "_tq_id"}, 128'(r.tq_id), 128'(e.tq));
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp8.valid) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp8_unexpected: got response tq_id %0d at cycle %0d, expected none",
                   rsp8.tq_id, cyc);
        end else begin
          cmp_rsp("rsp8", rsp8, q8[0]);
          q8.delete(0);
        end
      end else if (q8.size() != 0 && q8[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL rsp8_missing: no response by cycle %0d, expected at cycle %0d",
                 cyc, q8[0].due);
        q8.delete(0);
      end
      if (int'(pend8) > peak8) peak8 = int'(pend8);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp16.valid) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp16_unexpected: got response tq_id %0d at cycle %0d, expected none",
                   rsp16.tq_id, cyc);
        end else begin
          cmp_rsp("rsp16", rsp16, q16[0]);
          q16.delete(0);
        end
      end else if (q16.size() != 0 && q16[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL rsp16_missing: no response by cycle %0d, expected at cycle %0d",
                 cyc, q16[0].due);
        q16.delete(0);
      end
    end
  end

  // Drives one request for one cycle (called #1 after a posedge, returns
  // #1 after the accept edge). A fill that should answer queues its
  // expectation: accept edge is cyc+1, response visible LATENCY edges later.
  task automatic send(input bit sel, input t_fm_opcode op, input logic vld,
                      input int addr, input logic [63:0] data, input int tq,
                      input bit exp_rsp, input logic [63:0] exp_data);
    t_fm_req r;
    exp_t    e;
    r.valid   = vld;
    r.opcode  = op;
    r.address = LINE_ADDR_W'(addr);
    r.data    = data;
    r.tq_id   = TQ_ID_W'(tq);
    if (sel) req16 = r; else req8 = r;
    if (exp_rsp) begin
      e.due  = cyc + 1 + (sel ? 16 : 8);
      e.addr = r.address;
      e.data = exp_data;
      e.tq   = r.tq_id;
      if (sel) q16.push_back(e); else q8.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) req16.valid = 1'b0; else req8.valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (q8.size() != 0 || q16.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_outstanding", 128'(q8.size() + q16.size()), 128'(0));
  endtask

  initial begin
    rst   = 1'b1;
    req8  = '0;
    req16 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("reset_rsp8",  128'(rsp8), 128'(0));
    check("reset_rsp16", 128'(rsp16), 128'(0));
    check("reset_pend8", 128'(pend8), 128'(0));
    check("reset_ovf8",  128'(ovf8), 128'(0));
    check("reset_ovf16", 128'(ovf16), 128'(0));

    // Single fill of a preloaded line; pending is 1 up to the pop edge.
    send(0, DIRTY_EVICT_OP, 1'b1, 5, DAT_A, 0, 1'b0, '0);
    send(0, FILL_REQ_OP,    1'b1, 5, '0,    2, 1'b1, DAT_A);
    check("single_pend_after_accept", 128'(pend8), 128'(1));
    repeat (7) @(posedge clk);
    #1;
    check("single_pend_before_pop", 128'(pend8), 128'(1));
    @(posedge clk);
    #1;
    check("single_pend_after_pop", 128'(pend8), 128'(0));
    wait_drain();

    // Evict then fill next cycle sees the new data.
    send(0, DIRTY_EVICT_OP, 1'b1, 9, DAT_B, 0, 1'b0, '0);
    send(0, FILL_REQ_OP,    1'b1, 9, '0,    3, 1'b1, DAT_B);
    wait_drain();

    // Unknown opcode and valid=0 evict are ignored; line 9 keeps DAT_B.
    send(0, t_fm_opcode'(2'd3), 1'b1, 9, DAT_D, 0, 1'b0, '0);
    send(0, DIRTY_EVICT_OP,     1'b0, 9, DAT_D, 0, 1'b0, '0);
    send(0, FILL_REQ_OP,        1'b1, 9, '0,    4, 1'b1, DAT_B);
    // Address 261 aliases onto line 5; full address is echoed back.
    send(0, FILL_REQ_OP,        1'b1, 261, '0,  5, 1'b1, DAT_A);
    wait_drain();

    // Back-to-back: 8 fills, tq_id 0..7, responses in order one per cycle.
    for (int i = 0; i < 8; i++) send(0, DIRTY_EVICT_OP, 1'b1, 16 + i, 64'h1000 + 64'(i), 0, 1'b0, '0);
    peak8 = 0;
    for (int i = 0; i < 8; i++) send(0, FILL_REQ_OP, 1'b1, 16 + i, '0, i, 1'b1, 64'h1000 + 64'(i));
    wait_drain();
    check("b2b_peak_pending", 128'(peak8), 128'(8));
    check("b2b_ovf", 128'(ovf8), 128'(0));

    // Full with pop: 9th fill coincides with the first pop and is kept.
    for (int i = 0; i < 9; i++) send(0, DIRTY_EVICT_OP, 1'b1, 24 + i, 64'h2000 + 64'(i), 0, 1'b0, '0);
    for (int i = 0; i < 9; i++) send(0, FILL_REQ_OP, 1'b1, 24 + i, '0, i + 7, 1'b1, 64'h2000 + 64'(i));
    check("fullpop_pend", 128'(pend8), 128'(8));
    check("fullpop_ovf_now", 128'(ovf8), 128'(0));
    wait_drain();
    check("fullpop_ovf_end", 128'(ovf8), 128'(0));

    // Overflow on the LATENCY=16 instance: 9th fill dropped, error sticky.
    for (int i = 0; i < 9; i++) send(1, DIRTY_EVICT_OP, 1'b1, 40 + i, 64'h3000 + 64'(i), 0, 1'b0, '0);
    for (int i = 0; i < 9; i++) send(1, FILL_REQ_OP, 1'b1, 40 + i, '0, i, (i < 8), 64'h3000 + 64'(i));
    check("ovf_pend16", 128'(pend16), 128'(8));
    check("ovf_flag_set", 128'(ovf16), 128'(1));
    wait_drain();
    check("ovf_flag_sticky", 128'(ovf16), 128'(1));

    // Reset mid-flight: in-flight fills vanish, memory survives.
    send(0, DIRTY_EVICT_OP, 1'b1, 50, DAT_C, 0, 1'b0, '0);
    for (int i = 0; i < 3; i++) send(0, FILL_REQ_OP, 1'b1, 50, '0, i + 1, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_pend8", 128'(pend8), 128'(0));
    check("rstmid_rsp_vld", 128'(rsp8.valid), 128'(0));
    check("rstmid_ovf16_cleared", 128'(ovf16), 128'(0));
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_pend8_quiet", 128'(pend8), 128'(0));
    send(0, FILL_REQ_OP, 1'b1, 50, '0, 7, 1'b1, DAT_C);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
